// File: rtl/slc3_mem_bridge.sv
// slc3_mem_bridge: SLC-3 memory stage driving an async SRAM and one I/O word.
// Optional access counters are built when SLC3_MEM_BRIDGE_STATS_EN is defined.
module slc3_mem_bridge #(
   parameter int                ADDR_W       = 20,
   parameter int                READ_WAIT    = 2,
   parameter int                WRITE_CYCLES = 1,
   parameter logic [ADDR_W-1:0] IO_ADDR      = 20'h0FFFF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Mem_OE,
   input  logic              Mem_WE,
   input  logic [15:0]       MAR,
   input  logic [15:0]       Data_from_CPU,
   output logic [15:0]       Data_to_CPU,
   output logic              Mem_Ready,
   input  logic [15:0]       Switches,
   output logic [15:0]       HEX_Out,
   output logic              CE_N,
   output logic              OE_N,
   output logic              WE_N,
   output logic              UB_N,
   output logic              LB_N,
   output logic [ADDR_W-1:0] ADDR,
   output logic [15:0]       Data_to_SRAM,
   output logic              Data_OE,
   input  logic [15:0]       Data_from_SRAM,
   output logic [15:0]       Rd_Count,
   output logic [15:0]       Wr_Count
);

   typedef enum logic [3:0] {
      IDLE, RD_SETUP, RD_WAIT, RD_CAPT,
      WR_SETUP, WR_PULSE, WR_HOLD,
      IO_RD, IO_WR, DONE, RELEASE
   } state_t;

   localparam logic [15:0] RD_LAST = 16'(READ_WAIT - 1);
   localparam logic [15:0] WR_LAST = 16'(WRITE_CYCLES - 1);

   state_t              state_q, state_d;
   logic [15:0]         wait_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [15:0]         wdata_q;
   logic                is_wr_q;
   logic [ADDR_W-1:0]   mar_ext;
   logic                is_io;
   logic                ce_n_d, oe_n_d, we_n_d, doe_d, rdy_d;
   logic                sram_st, wr_st;

   assign mar_ext = ADDR_W'(MAR);
   assign is_io   = (mar_ext == IO_ADDR);

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic and per-state SRAM control levels
   always_comb begin
      state_d = state_q;
      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      we_n_d  = 1'b1;
      doe_d   = 1'b0;
      rdy_d   = 1'b0;
      sram_st = 1'b0;
      wr_st   = 1'b0;
      case (state_q)
         IDLE: begin
            if (Mem_WE)      state_d = is_io ? IO_WR : WR_SETUP;
            else if (Mem_OE) state_d = is_io ? IO_RD : RD_SETUP;
         end
         RD_SETUP: begin
            ce_n_d = 1'b0; oe_n_d = 1'b0; sram_st = 1'b1;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            ce_n_d = 1'b0; oe_n_d = 1'b0; sram_st = 1'b1;
            if (wait_q == RD_LAST) state_d = RD_CAPT;
         end
         RD_CAPT: begin
            ce_n_d = 1'b0; oe_n_d = 1'b0; sram_st = 1'b1;
            state_d = DONE;
         end
         WR_SETUP: begin
            ce_n_d = 1'b0; doe_d = 1'b1; sram_st = 1'b1; wr_st = 1'b1;
            state_d = WR_PULSE;
         end
         WR_PULSE: begin
            ce_n_d = 1'b0; doe_d = 1'b1; we_n_d = 1'b0;
            sram_st = 1'b1; wr_st = 1'b1;
            if (wait_q == WR_LAST) state_d = WR_HOLD;
         end
         WR_HOLD: begin
            ce_n_d = 1'b0; doe_d = 1'b1; sram_st = 1'b1; wr_st = 1'b1;
            state_d = DONE;
         end
         IO_RD, IO_WR: state_d = DONE;
         DONE: begin
            rdy_d   = 1'b1;
            state_d = RELEASE;
         end
         RELEASE: if (!Mem_OE && !Mem_WE) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Dwell counter for RD_WAIT and WR_PULSE
   always_ff @(posedge Clk) begin
      if (Reset || (state_q != RD_WAIT && state_q != WR_PULSE)) wait_q <= '0;
      else                                                       wait_q <= wait_q + 16'd1;
   end

   // Request latch and registered data paths
   always_ff @(posedge Clk) begin
      if (Reset) begin
         addr_q       <= '0;
         wdata_q      <= '0;
         is_wr_q      <= 1'b0;
         Data_to_CPU  <= '0;
         HEX_Out      <= '0;
         ADDR         <= '0;
         Data_to_SRAM <= '0;
      end else begin
         if (state_q == IDLE && (Mem_WE || Mem_OE)) begin
            addr_q  <= mar_ext;
            wdata_q <= Data_from_CPU;
            is_wr_q <= Mem_WE;
         end
         if (state_q == RD_CAPT) Data_to_CPU <= Data_from_SRAM;
         if (state_q == IO_RD)   Data_to_CPU <= Switches;
         if (state_q == IO_WR)   HEX_Out <= wdata_q;
         if (sram_st)            ADDR <= addr_q;
         if (wr_st)              Data_to_SRAM <= wdata_q;
      end
   end

   // Registered SRAM strobes and completion pulse
   always_ff @(posedge Clk) begin
      if (Reset) begin
         CE_N      <= 1'b1;
         UB_N      <= 1'b1;
         LB_N      <= 1'b1;
         OE_N      <= 1'b1;
         WE_N      <= 1'b1;
         Data_OE   <= 1'b0;
         Mem_Ready <= 1'b0;
      end else begin
         CE_N      <= ce_n_d;
         UB_N      <= ce_n_d;
         LB_N      <= ce_n_d;
         OE_N      <= oe_n_d;
         WE_N      <= we_n_d;
         Data_OE   <= doe_d;
         Mem_Ready <= rdy_d;
      end
   end

`ifdef SLC3_MEM_BRIDGE_STATS_EN
   // Completed-access counters, bumped as each access finishes
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Rd_Count <= '0;
         Wr_Count <= '0;
      end else if (state_q == DONE) begin
         if (is_wr_q) Wr_Count <= Wr_Count + 16'd1;
         else         Rd_Count <= Rd_Count + 16'd1;
      end
   end
`else
   assign Rd_Count = '0;
   assign Wr_Count = '0;
`endif

endmodule
